// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite response encoding and parameter helpers for the register file.
// The helpers let each module derive its index width and reject unsupported shapes at elaboration.
package axi4lite_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      SLVERR = 2'b10
   } resp_t;

   function automatic int addr_lsb(input int data_width);
      return $clog2(data_width / 8);
   endfunction

   function automatic bit data_width_ok(input int data_width);
      return (data_width == 32) || (data_width == 64);
   endfunction

   function automatic bit num_regs_ok(input int num_regs, input int addr_width, input int data_width);
      return (num_regs >= 1) && (num_regs <= (1 << (addr_width - addr_lsb(data_width))));
   endfunction

endpackage

// File: rtl/axi4lite_hold_reg.sv
// One-entry holding register for an AXI4-Lite request channel.
// Accepts a beat while empty and keeps it until the consumer clears it.
module axi4lite_hold_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic             clear_i,
   output logic             full_o,
   output logic [WIDTH-1:0] data_o
);

   logic             full_q, full_d;
   logic [WIDTH-1:0] data_q, data_d;

   // en_i keeps ready low while the block is still coming out of reset.
   assign ready_o = en_i && !full_q;
   assign full_o  = full_q;
   assign data_o  = data_q;

   always_comb begin
      full_d = full_q;
      data_d = data_q;
      if (clear_i) begin
         full_d = 1'b0;
      end
      if (valid_i && ready_o) begin
         full_d = 1'b1;
         data_d = data_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
      end
   end

endmodule

// File: rtl/axi4lite_regfile.sv
// AXI4-Lite slave register file with byte strobes, read-only status slots and write pulses.
// Write address and data are buffered independently and committed together once both are held.
module axi4lite_regfile
   import axi4lite_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 6,
   parameter int                    NUM_REGS   = 16,
   parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
   parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
   input  logic                           s_axi_aclk,
   input  logic                           s_axi_areset,
   input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
   input  logic                           s_axi_awvalid,
   output logic                           s_axi_awready,
   input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
   input  logic                           s_axi_wvalid,
   output logic                           s_axi_wready,
   output logic [1:0]                     s_axi_bresp,
   output logic                           s_axi_bvalid,
   input  logic                           s_axi_bready,
   input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
   input  logic                           s_axi_arvalid,
   output logic                           s_axi_arready,
   output logic [DATA_WIDTH-1:0]          s_axi_rdata,
   output logic [1:0]                     s_axi_rresp,
   output logic                           s_axi_rvalid,
   input  logic                           s_axi_rready,
   output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] status_i,
   output logic [NUM_REGS-1:0]            wr_pulse_o
);

   localparam int LSB   = addr_lsb(DATA_WIDTH);
   localparam int IDXW  = ADDR_WIDTH - LSB;
   localparam int STRBW = DATA_WIDTH / 8;

   if (!data_width_ok(DATA_WIDTH)) begin : g_bad_data_width
      $error("axi4lite_regfile: DATA_WIDTH must be 32 or 64");
   end
   if (!num_regs_ok(NUM_REGS, ADDR_WIDTH, DATA_WIDTH)) begin : g_bad_num_regs
      $error("axi4lite_regfile: NUM_REGS does not fit the address space");
   end

   logic                  en_q;
   logic                  aw_full, w_full, commit, wr_ok, ar_hs;
   logic [IDXW-1:0]       aw_idx, ar_idx;
   logic [DATA_WIDTH-1:0] w_data, rd_val;
   logic [STRBW-1:0]      w_strb;
   logic [NUM_REGS-1:0]   wr_sel, wr_pulse_q, wr_pulse_d;
   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
   logic                  bvalid_q, bvalid_d, rvalid_q, rvalid_d;
   resp_t                 bresp_q, bresp_d, rresp_q, rresp_d, rd_resp;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  unused_inputs;

   // Sub-word address bits and the status slices of RW registers carry no meaning here.
   assign unused_inputs = ^{s_axi_awaddr[LSB-1:0], s_axi_araddr[LSB-1:0], status_i};

   axi4lite_hold_reg #(.WIDTH(IDXW)) u_aw_hold (
      .clk_i   (s_axi_aclk),
      .rst_i   (s_axi_areset),
      .en_i    (en_q),
      .data_i  (s_axi_awaddr[ADDR_WIDTH-1:LSB]),
      .valid_i (s_axi_awvalid),
      .ready_o (s_axi_awready),
      .clear_i (commit),
      .full_o  (aw_full),
      .data_o  (aw_idx)
   );

   axi4lite_hold_reg #(.WIDTH(DATA_WIDTH + STRBW)) u_w_hold (
      .clk_i   (s_axi_aclk),
      .rst_i   (s_axi_areset),
      .en_i    (en_q),
      .data_i  ({s_axi_wstrb, s_axi_wdata}),
      .valid_i (s_axi_wvalid),
      .ready_o (s_axi_wready),
      .clear_i (commit),
      .full_o  (w_full),
      .data_o  ({w_strb, w_data})
   );

   assign commit = aw_full && w_full && !bvalid_q;
   assign ar_idx = s_axi_araddr[ADDR_WIDTH-1:LSB];
   assign ar_hs  = s_axi_arvalid && s_axi_arready;

   always_comb begin
      wr_sel = '0;
      wr_ok  = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (aw_idx == IDXW'(i)) begin
            wr_sel[i] = !RO_MASK[i];
            wr_ok     = !RO_MASK[i];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_d[i] = regs_q[i];
         if (commit && wr_sel[i]) begin
            for (int b = 0; b < STRBW; b++) begin
               if (w_strb[b]) begin
                  regs_d[i][b*8 +: 8] = w_data[b*8 +: 8];
               end
            end
         end
      end
      wr_pulse_d = commit ? wr_sel : '0;
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      if (commit) begin
         bvalid_d = 1'b1;
         bresp_d  = wr_ok ? OKAY : SLVERR;
      end else if (bvalid_q && s_axi_bready) begin
         bvalid_d = 1'b0;
      end
   end

   // Reads sample regs_q before any same-edge commit, so they see the old value.
   always_comb begin
      rd_val  = '0;
      rd_resp = SLVERR;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (ar_idx == IDXW'(i)) begin
            rd_resp = OKAY;
            rd_val  = RO_MASK[i] ? status_i[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
         end
      end
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      if (ar_hs) begin
         rvalid_d = 1'b1;
         rdata_d  = rd_val;
         rresp_d  = rd_resp;
      end else if (rvalid_q && s_axi_rready) begin
         rvalid_d = 1'b0;
      end
   end

   always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
      if (s_axi_areset) begin
         en_q       <= 1'b0;
         wr_pulse_q <= '0;
         bvalid_q   <= 1'b0;
         bresp_q    <= OKAY;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         rresp_q    <= OKAY;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= RESET_VAL;
         end
      end else begin
         en_q       <= 1'b1;
         wr_pulse_q <= wr_pulse_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   always_comb begin
      regs_o = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_o[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
      end
   end

   assign s_axi_arready = en_q && !rvalid_q;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bresp   = bresp_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rresp   = rresp_q;
   assign wr_pulse_o    = wr_pulse_q;

endmodule

// File: tb/tb_axi4lite_regfile.sv
// Bench for axi4lite_regfile: directed protocol cases, then random traffic against a register model.
module tb_axi4lite_regfile;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int NR = 8;
  localparam logic [NR-1:0] RO = 8'hA0;
  localparam logic [DW-1:0] RV = 32'h1111_0000;

  logic clk, rst;
  logic [AW-1:0] awaddr, araddr;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [3:0] wstrb;
  logic [1:0] bresp, rresp;
  logic [NR*DW-1:0] regs_flat, status_flat;
  logic [NR-1:0] wr_pulse;

  logic [DW-1:0] mdl [NR];
  logic [DW-1:0] stat [NR];
  logic [NR-1:0] ro_m;

  int total = 0;
  int bad = 0;

  axi4lite_regfile #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .RO_MASK(RO), .RESET_VAL(RV)
  ) dut (
    .s_axi_aclk(clk), .s_axi_areset(rst),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .regs_o(regs_flat), .status_i(status_flat), .wr_pulse_o(wr_pulse)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NR; i++) status_flat[i*DW +: DW] = stat[i];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] reg_of(input int i);
    return regs_flat[i*DW +: DW];
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [DW+1:0] model_read(input logic [AW-1:0] a);
    int idx;
    idx = int'(a) / 4;
    if (idx >= NR) return {2'b10, 32'h0};
    if (ro_m[idx]) return {2'b00, stat[idx]};
    return {2'b00, mdl[idx]};
  endfunction

  // returns {resp, pulse}
  function automatic logic [NR+1:0] model_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                                input logic [3:0] s);
    int idx;
    logic [NR-1:0] p;
    idx = int'(a) / 4;
    p = '0;
    if (idx >= NR || ro_m[idx]) return {2'b10, p};
    for (int b = 0; b < 4; b++) if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
    p[idx] = 1'b1;
    return {2'b00, p};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly,
                           output logic [1:0] resp, output int lat,
                           output logic [NR-1:0] p_b, output logic [NR-1:0] p_next);
    bit aw_done, w_done, aw_hs, w_hs;
    int cyc;
    aw_done = 0; w_done = 0; cyc = 0;
    while (!(aw_done && w_done) && cyc < 50) begin
      @(negedge clk);
      awvalid = !aw_done && (cyc >= aw_dly); awaddr = addr;
      wvalid = !w_done && (cyc >= w_dly); wdata = data; wstrb = strb;
      aw_hs = awvalid && awready;
      w_hs = wvalid && wready;
      @(posedge clk);
      if (aw_hs) aw_done = 1;
      if (w_hs) w_done = 1;
      cyc++;
    end
    if (!(aw_done && w_done)) check_val("wr_accept_timeout", 0, 1);
    lat = 0;
    do begin
      @(negedge clk);
      awvalid = 0; wvalid = 0;
      lat++;
    end while (!bvalid && lat < 50);
    if (!bvalid) check_val("b_timeout", 0, 1);
    resp = bresp;
    p_b = wr_pulse;
    bready = 1;
    @(posedge clk);
    @(negedge clk);
    bready = 0;
    p_next = wr_pulse;
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, output logic [DW-1:0] data, output logic [1:0] resp);
    bit hs;
    int cyc;
    hs = 0; cyc = 0;
    while (!hs && cyc < 50) begin
      @(negedge clk);
      arvalid = 1; araddr = addr;
      hs = arready;
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    arvalid = 0;
    if (!hs || !rvalid) check_val("r_timeout", 0, 1);
    data = rdata;
    resp = rresp;
    rready = 1;
    @(posedge clk);
    @(negedge clk);
    rready = 0;
  endtask

  task automatic run_random(input int ncyc);
    logic [AW-1:0] aw_q[$];
    logic [DW+3:0] w_q[$];
    logic [DW+1:0] exp_q[$];
    logic [AW-1:0] a;
    logic [DW+3:0] wd;
    logic [DW+1:0] e;
    logic [NR+1:0] mw;
    bit aw_hs, w_hs, ar_hs, r_hs, b_hs, bv_prev;
    int aw_n, w_n, ar_n, r_n, b_n, cyc;
    aw_hs = 0; w_hs = 0; ar_hs = 0; r_hs = 0; b_hs = 0; bv_prev = 0;
    aw_n = 0; w_n = 0; ar_n = 0; r_n = 0; b_n = 0; cyc = 0;
    while (cyc < ncyc || ((b_n != aw_n || w_n != aw_n || r_n != ar_n) && cyc < ncyc + 2000)) begin
      @(negedge clk);
      if (aw_hs) begin aw_q.push_back(awaddr); awvalid = 0; end
      if (w_hs) begin w_q.push_back({wstrb, wdata}); wvalid = 0; end
      // reads taken at the last edge see the registers before any commit on that edge
      if (ar_hs) begin exp_q.push_back(model_read(araddr)); arvalid = 0; end
      if (r_hs) begin
        r_n++;
        if (exp_q.size() == 0) check_val("r_spurious", 1, 0);
        else begin
          e = exp_q.pop_front();
          check_val("rnd_rdata", rdata, e[DW-1:0]);
          check_val("rnd_rresp", rresp, e[DW+1:DW]);
        end
      end
      if (b_hs) b_n++;
      if (bvalid && !bv_prev) begin
        if (aw_q.size() == 0 || w_q.size() == 0) check_val("b_spurious", 1, 0);
        else begin
          a = aw_q.pop_front();
          wd = w_q.pop_front();
          mw = model_write(a, wd[DW-1:0], wd[DW+3:DW]);
          check_val("rnd_bresp", bresp, mw[NR+1:NR]);
          check_val("rnd_pulse", wr_pulse, mw[NR-1:0]);
        end
      end else if (wr_pulse != '0) begin
        check_val("pulse_stray", wr_pulse, 0);
      end
      bv_prev = bvalid;
      if (!awvalid && ((cyc < ncyc) ? ($urandom_range(0, 2) == 0) : (aw_n < w_n))) begin
        awvalid = 1;
        awaddr = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(32, 63)) : AW'($urandom_range(0, 31));
        aw_n++;
      end
      if (!wvalid && ((cyc < ncyc) ? ($urandom_range(0, 2) == 0) : (w_n < aw_n))) begin
        wvalid = 1;
        wdata = $urandom;
        wstrb = 4'($urandom_range(0, 15));
        w_n++;
      end
      if (!arvalid && cyc < ncyc && $urandom_range(0, 1) == 0) begin
        arvalid = 1;
        araddr = AW'($urandom_range(0, 63));
        ar_n++;
      end
      bready = ($urandom_range(0, 3) != 0);
      rready = ($urandom_range(0, 3) != 0);
      aw_hs = awvalid && awready;
      w_hs = wvalid && wready;
      ar_hs = arvalid && arready;
      r_hs = rvalid && rready;
      b_hs = bvalid && bready;
      cyc++;
    end
    @(negedge clk);
    bready = 0; rready = 0;
    check_val("rnd_b_count", b_n, aw_n);
    check_val("rnd_w_count", w_n, aw_n);
    check_val("rnd_r_count", r_n, ar_n);
    check_val("rnd_r_left", exp_q.size(), 0);
    check_val("rnd_aw_left", aw_q.size(), 0);
    for (int i = 0; i < NR; i++) if (!ro_m[i]) check_val("rnd_final_reg", reg_of(i), mdl[i]);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [1:0] resp;
    logic [DW-1:0] data;
    logic [NR-1:0] p_b, p_next;
    int lat;

    ro_m = RO;
    for (int i = 0; i < NR; i++) begin
      stat[i] = 32'hC0DE_0000 | 32'(i);
      mdl[i] = RV;
    end
    stat[5] = 32'hCAFE_0005;
    rst = 1;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_awready", awready, 0);
    check_val("rst_wready", wready, 0);
    check_val("rst_arready", arready, 0);
    check_val("rst_bvalid", bvalid, 0);
    check_val("rst_rvalid", rvalid, 0);
    check_val("rst_bresp", bresp, 0);
    check_val("rst_rresp", rresp, 0);
    check_val("rst_rdata", rdata, 0);
    check_val("rst_pulse", wr_pulse, 0);
    for (int i = 0; i < NR; i++) if (!ro_m[i]) check_val("rst_reg", reg_of(i), RV);
    rst = 0;
    repeat (2) @(negedge clk);

    // AW and W together
    axi_write(6'h04, 32'hDEAD_BEEF, 4'hF, 0, 0, resp, lat, p_b, p_next);
    check_val("w1_bresp", resp, 2'b00);
    check_val("w1_b_latency", lat, 2);
    check_val("w1_pulse", p_b, 8'h02);
    check_val("w1_pulse_once", p_next, 8'h00);
    axi_read(6'h04, data, resp);
    check_val("r1_data", data, 32'hDEAD_BEEF);
    check_val("r1_resp", resp, 2'b00);

    // W leads AW by three cycles, partial strobes
    axi_write(6'h08, 32'hFFFF_FFFF, 4'hF, 0, 0, resp, lat, p_b, p_next);
    axi_write(6'h08, 32'h0000_1234, 4'h3, 3, 0, resp, lat, p_b, p_next);
    check_val("w2_bresp", resp, 2'b00);
    check_val("w2_b_latency", lat, 2);
    check_val("w2_pulse", p_b, 8'h04);
    axi_read(6'h08, data, resp);
    check_val("r2_data", data, 32'hFFFF_1234);

    // out of range and read-only targets
    axi_write(6'h3C, 32'h1234_5678, 4'hF, 1, 0, resp, lat, p_b, p_next);
    check_val("oor_bresp", resp, 2'b10);
    check_val("oor_pulse", p_b, 8'h00);
    axi_read(6'h3C, data, resp);
    check_val("oor_rdata", data, 32'h0);
    check_val("oor_rresp", resp, 2'b10);
    axi_write(6'h14, 32'h5555_5555, 4'hF, 0, 2, resp, lat, p_b, p_next);
    check_val("ro_bresp", resp, 2'b10);
    check_val("ro_pulse", p_b, 8'h00);
    check_val("ro_reg_kept", reg_of(5), RV);
    axi_read(6'h14, data, resp);
    check_val("ro_rdata", data, 32'hCAFE_0005);
    check_val("ro_rresp", resp, 2'b00);

    // unaligned address selects register 3
    axi_write(6'h0E, 32'hA5A5_5A5A, 4'hF, 0, 0, resp, lat, p_b, p_next);
    check_val("ua_pulse", p_b, 8'h08);
    axi_read(6'h0C, data, resp);
    check_val("ua_rdata", data, 32'hA5A5_5A5A);

    // B back-pressure blocks the second commit
    @(negedge clk);
    awvalid = 1; awaddr = 6'h18; wvalid = 1; wdata = 32'hAAAA_0006; wstrb = 4'hF; bready = 0;
    check_val("bp_awready_init", awready, 1);
    @(posedge clk);
    @(negedge clk);
    awaddr = 6'h10; wdata = 32'hBBBB_0004;
    check_val("bp_aw_held", awready, 0);
    check_val("bp_w_held", wready, 0);
    @(posedge clk);
    @(negedge clk);
    check_val("bp_bvalid_a", bvalid, 1);
    @(posedge clk);
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    repeat (3) @(negedge clk);
    check_val("bp_b_hold", bvalid, 1);
    check_val("bp_aw_blocked", awready, 0);
    check_val("bp_w_blocked", wready, 0);
    check_val("bp_reg6", reg_of(6), 32'hAAAA_0006);
    check_val("bp_reg4_old", reg_of(4), RV);
    bready = 1;
    @(posedge clk);
    @(negedge clk);
    bready = 0;
    check_val("bp_b_taken", bvalid, 0);
    @(negedge clk);
    check_val("bp_bvalid_b", bvalid, 1);
    check_val("bp_bresp_b", bresp, 2'b00);
    check_val("bp_pulse_b", wr_pulse, 8'h10);
    check_val("bp_reg4_new", reg_of(4), 32'hBBBB_0004);
    bready = 1;
    @(posedge clk);
    @(negedge clk);
    bready = 0;

    // R back-pressure, then reset in the middle of the read
    arvalid = 1; araddr = 6'h04; rready = 0;
    check_val("rb_arready", arready, 1);
    @(posedge clk);
    @(negedge clk);
    arvalid = 0;
    for (int k = 0; k < 3; k++) begin
      check_val("rb_rvalid", rvalid, 1);
      check_val("rb_rdata_hold", rdata, 32'hDEAD_BEEF);
      check_val("rb_ar_blocked", arready, 0);
      @(negedge clk);
    end
    #2 rst = 1;
    #1;
    check_val("rst_mid_rvalid", rvalid, 0);
    check_val("rst_mid_reg1", reg_of(1), RV);
    check_val("rst_mid_reg4", reg_of(4), RV);
    @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);

    // random traffic
    for (int i = 0; i < NR; i++) begin
      mdl[i] = RV;
      stat[i] = $urandom;
    end
    run_random(5000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
